param_ram: RTL and testbench
============================

# param_ram

Parametrised single-port synchronous RAM for the factorial datapath, the next generation of the fixed 256x64 operand store. Width and depth are configurable. The block adds an asynchronous active-low reset, a hardware clear engine that zeroes the array after reset or on command, a read-valid strobe, and an optional output pipeline register. It sits between the factorial control FSM and the operand/result storage and keeps the existing cen/wen command encoding.

## Interface
- DATA_W, default 64: word width in bits.
- ADDR_W, default 8: address width in bits.
- DEPTH, default 256: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cen  in  1  chip enable.
- wen  in  1  write enable; meaningful only with cen=1.
- s_addr  in  ADDR_W  word address.
- s_din  in  DATA_W  write data.
- clr  in  1  single-cycle request to zero the whole array.
- s_dout  out  DATA_W  read data; 0 whenever s_valid=0.
- s_valid  out  1  s_dout carries read data this cycle.
- busy  out  1  clear sweep in progress; accesses are ignored.

## Operation
- Command decode on each edge when the block is not busy:
  - cen=0: no operation.
  - cen=1, wen=0: read mem[s_addr].
  - cen=1, wen=1: write mem[s_addr] ← s_din; s_dout does not return data.
- Out-of-range address (s_addr ≥ DEPTH):
  - Write is dropped.
  - Read completes with s_valid=1 and s_dout=0.
- Clear FSM has two states:
  - IDLE (busy=0): commands accepted. clr=1 → CLEAR with clr_addr←0.
  - CLEAR (busy=1): each edge writes mem[clr_addr]←0 and increments clr_addr. The edge that writes address DEPTH-1 returns the FSM to IDLE.
  - clr=1 while in CLEAR restarts the sweep at address 0.
- Command priority: clr beats cen. Any command sampled on a clr edge, or while busy=1, is discarded and produces no s_valid.
- The array itself is not reset. Clearing is done only by the sweep.
- Reset values: state=CLEAR, clr_addr=0, busy=1, s_valid=0, s_dout=0, all pipeline registers 0.
  - Every reset therefore starts a full clear sweep.
  - A reset asserted mid-sweep or mid-read aborts it; the sweep restarts from address 0 after release.

## Timing
- Read latency is 1 cycle with the macro absent. A read sampled at edge t gives s_valid=1 and data on s_dout after edge t; both are 0 after edge t+1 unless another read was sampled at t+1.
- A write at edge t followed by a read of the same address at t+1 returns the new data.
- Back-to-back reads give one result per cycle with no bubbles.
- Sweep length: busy rises after the clr edge and stays high for exactly DEPTH cycles. After reset release it stays high for DEPTH edges.
- A read sampled the edge before a clr edge still completes normally with the pre-clear data.

## Configuration
- PARAM_RAM_OUTREG_EN defined:
  - Adds one output register stage; read latency is 2 cycles.
  - s_valid and s_dout are delayed together.
  - Throughput stays one read per cycle.
  - An in-flight read completes even if clr arrives the next edge.
- PARAM_RAM_OUTREG_EN undefined: read latency is 1 cycle as described above.

## Test plan
- Reset then idle, DEPTH=256:
  - busy=1 for 256 cycles after reset_n release, then 0.
  - A read of address 0x05 returns s_dout=0 with s_valid=1.
- Write/read, 64-bit:
  - Write 0x0000_0000_0000_0078 to address 0x05, then read 0x05 the next cycle.
  - s_dout=0x78 with s_valid=1 one cycle later (two cycles with PARAM_RAM_OUTREG_EN).
- Clear and priority:
  - After filling addresses 0..3 with 1..4, assert clr together with a write of 9 to address 2.
  - The write is dropped and busy=1 for DEPTH cycles; reads of 0..3 then return 0.
- Clear restart:
  - Assert clr again 10 cycles into a sweep.
  - busy stays high for DEPTH cycles counted from the second clr.
- Out-of-range, DEPTH=200 and ADDR_W=8:
  - Write 0xFF to address 250; a read of 250 returns 0 with s_valid=1.
  - Address 199 is still writable and readable.
- Async reset mid-stream:
  - Assert reset_n=0 mid-cycle during back-to-back reads.
  - s_valid and s_dout go to 0 immediately, without waiting for a clock edge.
  - After release the full sweep runs before reads are accepted.

Source files
------------

// File: rtl/param_ram.sv
// rtl/param_ram.sv - parametrised single-port RAM with clear sweep and read-valid strobe
//
// Optional build macro: PARAM_RAM_OUTREG_EN adds one output register stage,
// which makes the read latency 2 cycles.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; starts a full clear sweep
//   cen      chip enable
//   wen      write enable (with cen=1)
//   s_addr   word address
//   s_din    write data
//   clr      single-cycle request to zero the whole array
//   s_dout   read data, 0 whenever s_valid=0
//   s_valid  s_dout carries read data this cycle
//   busy     clear sweep in progress, commands ignored
module param_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              wen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  input  logic              clr,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_valid,
  output logic              busy
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              accept;
  logic              do_rd;
  logic              do_wr;
  logic [IDX_W-1:0]  acc_idx;
  logic [IDX_W-1:0]  clr_idx;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // Widened compare so DEPTH == 2**ADDR_W does not overflow.
  assign in_range = {1'b0, s_addr} < DEPTH_V;

  // clr wins over any command on the same edge; nothing is accepted while sweeping.
  assign accept   = (state == ST_IDLE) && !clr && cen;
  assign do_rd    = accept && !wen;
  assign do_wr    = accept && wen && in_range;
  assign acc_idx  = s_addr[IDX_W-1:0];
  assign clr_idx  = clr_addr[IDX_W-1:0];

  // Clear sweep controller. A clr while sweeping simply restarts at address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (clr) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state    <= ST_IDLE;
        clr_addr <= '0;
        busy     <= 1'b0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  // Storage array: never reset, zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_wr) begin
      mem[acc_idx] <= s_din;
    end
  end

  // First read stage. Out-of-range reads still strobe valid but return 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_rd;
      rd_data  <= (do_rd && in_range) ? mem[acc_idx] : '0;
    end
  end

`ifdef PARAM_RAM_OUTREG_EN
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  // Extra stage is free-running so an in-flight read survives a following clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rd_valid;
      out_data  <= rd_data;
    end
  end

  assign s_valid = out_valid;
  assign s_dout  = out_data;
`else
  assign s_valid = rd_valid;
  assign s_dout  = rd_data;
`endif

endmodule

// File: tb/tb_param_ram.sv
// tb/tb_param_ram.sv - self-checking bench for param_ram (DEPTH 256 and DEPTH 200 instances)
module tb_param_ram;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [7:0]  s_addr;
  logic [63:0] s_din;
  logic        clr;

  logic [63:0] s_dout_a, s_dout_b;
  logic        s_valid_a, s_valid_b;
  logic        busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  param_ram u_ram_a (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .wen     (wen),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .clr     (clr),
    .s_dout  (s_dout_a),
    .s_valid (s_valid_a),
    .busy    (busy_a)
  );

  param_ram #(.DATA_W(64), .ADDR_W(8), .DEPTH(200)) u_ram_b (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .wen     (wen),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .clr     (clr),
    .s_dout  (s_dout_b),
    .s_valid (s_valid_b),
    .busy    (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents, remaining sweep cycles, and the expected outputs.
  logic [63:0] mdl [2][256];
  int          dep [2] = '{256, 200};
  int          left [2];
  logic        pv [2];
  logic [63:0] pd [2];
  logic        ev [2];
  logic [63:0] ed [2];
  logic        eb [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = dep[k];
      for (int i = 0; i < 256; i++) mdl[k][i] = '0;
      pv[k] = 1'b0; pd[k] = '0;
      ev[k] = 1'b0; ed[k] = '0;
      eb[k] = 1'b1;
    end
  endtask

  task automatic model_edge(input int k);
    logic        rv;
    logic [63:0] rdat;
    rv = 1'b0;
    rdat = '0;
    if (clr) begin
      // The sweep's net effect: the array reads back all zero once busy falls.
      left[k] = dep[k];
      for (int i = 0; i < 256; i++) mdl[k][i] = '0;
    end else if (left[k] > 0) begin
      left[k]--;
    end else if (cen) begin
      if (wen) begin
        if (int'(s_addr) < dep[k]) mdl[k][s_addr] = s_din;
      end else begin
        rv = 1'b1;
        rdat = (int'(s_addr) < dep[k]) ? mdl[k][s_addr] : 64'h0;
      end
    end
`ifdef PARAM_RAM_OUTREG_EN
    ev[k] = pv[k];
    ed[k] = pd[k];
    pv[k] = rv;
    pd[k] = rdat;
`else
    ev[k] = rv;
    ed[k] = rdat;
`endif
    eb[k] = (left[k] > 0);
  endtask

  task automatic check_outputs();
    chk("busy_a",  64'(busy_a),    64'(eb[0]));
    chk("valid_a", 64'(s_valid_a), 64'(ev[0]));
    chk("dout_a",  s_dout_a,       ed[0]);
    chk("busy_b",  64'(busy_b),    64'(eb[1]));
    chk("valid_b", 64'(s_valid_b), 64'(ev[1]));
    chk("dout_b",  s_dout_b,       ed[1]);
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic c, input logic w, input logic [7:0] a,
                       input logic [63:0] d, input logic cl);
    cen = c; wen = w; s_addr = a; s_din = d; clr = cl;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b1;
    cen = 1'b0; wen = 1'b0; s_addr = '0; s_din = '0; clr = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #6 reset_n = 1'b1;

    // Full sweep after reset; busy per edge comes from the model.
    idle(256);
    idle(2);

    // Read of a freshly cleared word.
    drive(1'b1, 1'b0, 8'h05, 64'h0, 1'b0);
    idle(2);

    // Write then read the same address next cycle.
    drive(1'b1, 1'b1, 8'h05, 64'h78, 1'b0);
    drive(1'b1, 1'b0, 8'h05, 64'h0, 1'b0);
`ifdef PARAM_RAM_OUTREG_EN
    idle(1);
`endif
    chk("wr_rd_78_a", s_dout_a, 64'h78);
    chk("wr_rd_78_valid", 64'(s_valid_a), 64'h1);
    idle(2);

    // Fill 0..3, then clr with a simultaneous write that must be dropped.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(i), 64'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(i), 64'h0, 1'b0);
    drive(1'b1, 1'b1, 8'h02, 64'h9, 1'b1);
    idle(257);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(i), 64'h0, 1'b0);
    idle(2);

    // Sweep restart 10 cycles in.
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    idle(10);
    drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
    idle(257);

    // Out-of-range on the DEPTH=200 instance, and its last valid word.
    drive(1'b1, 1'b1, 8'd250, 64'hFF, 1'b0);
    drive(1'b1, 1'b0, 8'd250, 64'h0, 1'b0);
    drive(1'b1, 1'b1, 8'd199, 64'hA5A5_0000_1234_5678, 1'b0);
    drive(1'b1, 1'b0, 8'd199, 64'h0, 1'b0);
    idle(2);

    // Random traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), {32'($urandom), 32'($urandom)},
            1'($urandom_range(0, 99) == 0));
    end
    idle(260);

    // Back-to-back reads, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(i * 37), 64'h0, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid_a", 64'(s_valid_a), 64'h0);
    chk("async_dout_a",  s_dout_a,       64'h0);
    chk("async_valid_b", 64'(s_valid_b), 64'h0);
    chk("async_dout_b",  s_dout_b,       64'h0);
    chk("async_busy_a",  64'(busy_a),    64'h1);
    @(posedge clk);
    #1;
    check_outputs();
    #3 reset_n = 1'b1;

    // Reads issued during the post-reset sweep must be ignored.
    for (int i = 0; i < 258; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(i * 60), 64'h0, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
